// File: rtl/rf_mp_scoreboard.sv
// Multi-port architectural register file with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
`ifndef RF_SIZE
`define RF_SIZE 16
`endif
`ifndef RF_SIZE_LOG
`define RF_SIZE_LOG 4
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module rf_mp_scoreboard #(
    parameter int unsigned NUM_REGS = `RF_SIZE,
    parameter int unsigned ADDR_W   = `RF_SIZE_LOG,
    parameter int unsigned DATA_W   = `REG_LEN,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       set_en,
    input  logic [ADDR_W-1:0]          set_addr,
    output logic [NUM_REGS-1:0]        busy_vec
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Register 0 is never written or marked busy when hardwired to zero.
    function automatic bit writable(input int r);
        return !(ZR && r == 0);
    endfunction

    // Next state: ascending port order makes the highest port win; set is applied last.
    always_comb begin : next_state
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int j = 0; j < int'(NUM_WR); j++) begin
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r) && writable(r)) begin
                    mem_d[r]  = wr_data[j*DATA_W +: DATA_W];
                    busy_d[r] = 1'b0;
                end
            end
        end
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (set_en && set_addr == ADDR_W'(r) && writable(r)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Combinational read ports; indices at or beyond NUM_REGS match nothing and return zero.
    always_comb begin : read_mux
        logic [ADDR_W-1:0] ra;
`ifdef RF_BYPASS_EN
        logic hit;
        hit = 1'b0;
`endif
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            for (int r = 0; r < int'(NUM_REGS); r++) begin
                if (ra == ADDR_W'(r)) begin
                    rd_data[i*DATA_W +: DATA_W] = mem_q[r];
                    rd_busy[i]                  = busy_q[r];
                end
            end
`ifdef RF_BYPASS_EN
            // Forward same-cycle writes; a coincident set keeps showing the stored busy bit.
            hit = 1'b0;
            for (int j = 0; j < int'(NUM_WR); j++) begin
                if (!rst && wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ra &&
                    32'(ra) < NUM_REGS && !(ZR && ra == '0)) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                    hit = 1'b1;
                end
            end
            if (hit && !(set_en && set_addr == ra)) begin
                rd_busy[i] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Scoreboard bench for rf_mp_scoreboard: directed stimulus queues expectations, a negedge monitor checks them.
module tb_rf_mp_scoreboard;

    localparam int unsigned NR = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data, z_rd_data;
    logic [1:0]      rd_busy, z_rd_busy;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic            set_en;
    logic [AW-1:0]   set_addr;
    logic [NR-1:0]   busy_vec, z_busy_vec;

    rf_mp_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .set_en(set_en),
        .set_addr(set_addr), .busy_vec(busy_vec)
    );

    rf_mp_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(z_rd_data), .rd_busy(z_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .set_en(set_en),
        .set_addr(set_addr), .busy_vec(z_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          z;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [15:0] bv;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every queued expectation describes the outputs of the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.z) begin
                check({e.nm, ".d0"}, z_rd_data[31:0],  e.d0);
                check({e.nm, ".d1"}, z_rd_data[63:32], e.d1);
                check({e.nm, ".b0"}, 32'(z_rd_busy[0]), 32'(e.b0));
                check({e.nm, ".b1"}, 32'(z_rd_busy[1]), 32'(e.b1));
                check({e.nm, ".bv"}, 32'(z_busy_vec),   32'(e.bv));
            end else begin
                check({e.nm, ".d0"}, rd_data[31:0],  e.d0);
                check({e.nm, ".d1"}, rd_data[63:32], e.d1);
                check({e.nm, ".b0"}, 32'(rd_busy[0]), 32'(e.b0));
                check({e.nm, ".b1"}, 32'(rd_busy[1]), 32'(e.b1));
                check({e.nm, ".bv"}, 32'(busy_vec),   32'(e.bv));
            end
        end
    end

    task automatic push(input string nm, input bit z, input logic [31:0] d0, input logic [31:0] d1,
                        input logic b0, input logic b1, input logic [15:0] bv);
        exp_t e;
        e.nm = nm; e.z = z; e.d0 = d0; e.d1 = d1; e.b0 = b0; e.b1 = b1; e.bv = bv;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rst    = 1'b0;
        wr_en  = '0;
        set_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_data[p*DW +: DW]   = d;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        rd_addr = {a1, a0};
    endtask

    task automatic setb(input logic [AW-1:0] a);
        set_en   = 1'b1;
        set_addr = a;
    endtask

    initial begin
        int waits;
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; set_en = 1'b0; set_addr = '0;
        tick();
        clr();
        push("rst_init", 0, 0, 0, 0, 0, 16'h0000);
        push("rst_init_z", 1, 0, 0, 0, 0, 16'h0000);
        tick();

        // populate some state
        wr(0, 5, 32'h1234); wr(1, 6, 32'hDEAD); setb(7);
        tick(); clr();
        rd(6, 5);
        push("fill", 0, 32'h1234, 32'hDEAD, 0, 0, 16'h0080);
        push("fill_z", 1, 32'h1234, 32'hDEAD, 0, 0, 16'h0080);
        tick();

        // reset beats a same-cycle write
        rst = 1'b1; wr(0, 2, 32'h55);
        tick(); clr();
        rd(2, 5);
        push("rst_wr", 0, 0, 0, 0, 0, 16'h0000);
        push("rst_wr_z", 1, 0, 0, 0, 0, 16'h0000);
        tick();
        rd(7, 6);
        push("rst_all", 0, 0, 0, 0, 0, 16'h0000);
        tick();

        // basic two-port write
        wr(0, 1, 32'hA5); wr(1, 3, 32'h3C); rd(3, 1);
        push("wr_same_cyc", 0, BYP ? 32'hA5 : 32'h0, BYP ? 32'h3C : 32'h0, 0, 0, 16'h0000);
        tick(); clr();
        push("wr_basic", 0, 32'hA5, 32'h3C, 0, 0, 16'h0000);
        tick();

        // collision: higher port wins
        wr(0, 2, 32'h11); wr(1, 2, 32'h22); rd(2, 2);
        push("coll_same", 0, BYP ? 32'h22 : 32'h0, BYP ? 32'h22 : 32'h0, 0, 0, 16'h0000);
        tick(); clr();
        push("coll", 0, 32'h22, 32'h22, 0, 0, 16'h0000);
        push("coll_z", 1, 32'h22, 32'h22, 0, 0, 16'h0000);
        tick();

        // set marks busy
        setb(1);
        tick(); clr();
        rd(3, 1);
        push("set", 0, 32'hA5, 32'h3C, 1, 0, 16'h0002);
        tick();

        // write clears busy
        wr(0, 1, 32'h7); rd(1, 1);
        push("clr_same", 0, BYP ? 32'h7 : 32'hA5, BYP ? 32'h7 : 32'hA5, !BYP, !BYP, 16'h0002);
        tick(); clr();
        push("clr", 0, 32'h7, 32'h7, 0, 0, 16'h0000);
        tick();

        // set and write together: busy ends set
        wr(0, 1, 32'h8); setb(1);
        push("setwr_same", 0, BYP ? 32'h8 : 32'h7, BYP ? 32'h8 : 32'h7, 0, 0, 16'h0000);
        tick(); clr();
        push("setwr", 0, 32'h8, 32'h8, 1, 1, 16'h0002);
        tick();

        // set of already-busy register, then another register
        setb(1);
        tick();
        setb(4);
        tick(); clr();
        rd(4, 1);
        push("rebusy", 0, 32'h8, 32'h0, 1, 1, 16'h0012);
        push("rebusy_z", 1, 32'h8, 32'h0, 1, 1, 16'h0012);
        tick();

        // register 0: normal in the default instance, hardwired in the zero instance
        wr(0, 0, 32'hFF); setb(0); rd(0, 0);
        push("r0_same", 0, BYP ? 32'hFF : 32'h0, BYP ? 32'hFF : 32'h0, 0, 0, 16'h0012);
        push("r0_same_z", 1, 0, 0, 0, 0, 16'h0012);
        tick(); clr();
        push("r0", 0, 32'hFF, 32'hFF, 1, 1, 16'h0013);
        push("r0_z", 1, 0, 0, 0, 0, 16'h0012);
        tick();

        // same-cycle visibility of a write
        wr(0, 3, 32'h9C); rd(3, 3);
        push("byp_same", 0, BYP ? 32'h9C : 32'h3C, BYP ? 32'h9C : 32'h3C, 0, 0, 16'h0013);
        tick(); clr();
        push("byp_next", 0, 32'h9C, 32'h9C, 0, 0, 16'h0013);
        tick();

        // final reset clears data and busy
        rst = 1'b1;
        tick(); clr();
        rd(3, 1);
        push("rst_final", 0, 0, 0, 0, 0, 16'h0000);
        push("rst_final_z", 1, 0, 0, 0, 0, 16'h0000);
        tick();

        waits = 0;
        while (q.size() > 0 && waits < 10) begin
            tick();
            waits++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
